// File: rtl/csa_pipelined_accumulator.sv
// Two-stage multi-operand adder/accumulator: S1 reduces NUM_OPS operands to a
// carry-save pair, S2 merges the pair with the accumulator and resolves it.
module csa_pipelined_accumulator #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4,
  parameter int ACC_W   = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  input  logic                     in_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_ovf
);

  if (NUM_OPS < 3 || NUM_OPS > 8) begin : g_bad_num_ops
    $error("NUM_OPS must lie in 3..8");
  end
  if (ACC_W < WIDTH + $clog2(NUM_OPS)) begin : g_bad_acc_w
    $error("ACC_W too narrow to hold the sum of NUM_OPS operands");
  end

  function automatic logic [ACC_W-1:0] csa_sum(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic [ACC_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [ACC_W-1:0] csa_maj(input logic [ACC_W-1:0] x,
                                               input logic [ACC_W-1:0] y,
                                               input logic [ACC_W-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Majority bits carry into the next column, so the MSB lands in bit ACC_W.
  function automatic logic [ACC_W:0] cpa(input logic [ACC_W-1:0] s,
                                         input logic [ACC_W-1:0] m);
    return {1'b0, s} + {m, 1'b0};
  endfunction

  logic             s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0] sum_p1_q, sum_p1_d;
  logic [ACC_W-1:0] carry_p1_q, carry_p1_d;
  logic             clr_p1_q, clr_p1_d;
  logic             out_vld_q, out_vld_d;
  logic [ACC_W-1:0] acc_p2_q, acc_p2_d;
  logic             ovf_p2_q, ovf_p2_d;

  logic             s1_load, s2_load;
  logic [ACC_W-1:0] tree_sum, tree_carry, op_ext, maj_tmp;
  logic [ACC_W-1:0] base_a;
  logic [ACC_W:0]   result_p2;

  // Stage 1: carry-save reduction of the incoming operands
  always_comb begin
    op_ext     = '0;
    maj_tmp    = '0;
    tree_sum   = ACC_W'(in_ops[WIDTH-1:0]);
    tree_carry = ACC_W'(in_ops[2*WIDTH-1:WIDTH]);
    for (int k = 2; k < NUM_OPS; k++) begin
      op_ext     = ACC_W'(in_ops[k*WIDTH +: WIDTH]);
      maj_tmp    = csa_maj(tree_sum, tree_carry, op_ext) << 1;
      tree_sum   = csa_sum(tree_sum, tree_carry, op_ext);
      tree_carry = maj_tmp;
    end
  end

  // Stage 2: fold the pair into the accumulator (or zero on clear)
  always_comb begin
    base_a    = clr_p1_q ? '0 : acc_p2_q;
    result_p2 = cpa(csa_sum(sum_p1_q, carry_p1_q, base_a),
                    csa_maj(sum_p1_q, carry_p1_q, base_a));
  end

  always_comb begin
    s2_load  = s1_vld_q & (~out_vld_q | out_ready);
    in_ready = ~rst & (~s1_vld_q | s2_load);
    s1_load  = in_valid & in_ready;

    s1_vld_d   = s1_vld_q;
    sum_p1_d   = sum_p1_q;
    carry_p1_d = carry_p1_q;
    clr_p1_d   = clr_p1_q;
    if (s1_load) begin
      s1_vld_d   = 1'b1;
      sum_p1_d   = tree_sum;
      carry_p1_d = tree_carry;
      clr_p1_d   = in_clear;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end

    out_vld_d = out_vld_q;
    acc_p2_d  = acc_p2_q;
    ovf_p2_d  = ovf_p2_q;
    if (s2_load) begin
      out_vld_d = 1'b1;
      acc_p2_d  = result_p2[ACC_W-1:0];
      ovf_p2_d  = result_p2[ACC_W];
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      acc_p2_q  <= '0;
      ovf_p2_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      out_vld_q <= out_vld_d;
      acc_p2_q  <= acc_p2_d;
      ovf_p2_q  <= ovf_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    sum_p1_q   <= sum_p1_d;
    carry_p1_q <= carry_p1_d;
    clr_p1_q   <= clr_p1_d;
  end

  assign out_valid = out_vld_q;
  assign out_sum   = acc_p2_q;
  assign out_ovf   = ovf_p2_q;

endmodule
